// File: rtl/aes3_pkg.sv
// Shared types and constants for the AES3 subframe deframer.
// Field states, slot lengths and the channel-status CRC step.
package aes3_pkg;

  typedef enum logic [2:0] {
    HUNT, AUX, DATA, VALID, USER, CHAN, PARITY
  } field_state_t;

  localparam int AUX_LEN  = 4;
  localparam int DATA_LEN = 20;
  localparam int SF_LEN   = AUX_LEN + DATA_LEN + 4;

  localparam logic [7:0] CS_CRC_POLY_REF = 8'hB8;
  localparam logic [7:0] CS_CRC_INIT     = 8'hFF;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       d
  );
    return (crc >> 1) ^ ((crc[0] ^ d) ? CS_CRC_POLY_REF : 8'h00);
  endfunction

endpackage

// File: rtl/aes3_subframe_deframer_crc.sv
// Bit-serial reflected CRC-8 over one channel's status bits.
// init has priority over a bit arriving on the same cycle.
module cs_crc8_serial
  import aes3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       bit_v,
  input  logic       bit_d,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init)
      crc <= CS_CRC_INIT;
    else if (bit_v)
      crc <= crc8_step(crc, bit_d);
  end

endmodule

// File: rtl/aes3_subframe_deframer.sv
// AES3/S/PDIF subframe deframer: sample records, position tracking,
// per-channel channel-status block assembly with CRC check.
module aes3_subframe_deframer
  import aes3_pkg::*;
#(
  parameter  int SAMPLE_W     = 24,
  parameter  int NUM_CH       = 2,
  parameter  int BLOCK_FRAMES = 192,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FR_W = $clog2(BLOCK_FRAMES)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vin,
  input  logic                    din,
  input  logic                    sof,
  input  logic                    block_start,
  output logic                    sample_vout,
  output logic [SAMPLE_W-1:0]     sample_data,
  output logic [3:0]              sample_aux,
  output logic [CH_W-1:0]         sample_ch,
  output logic                    sample_v,
  output logic                    sample_u,
  output logic                    parity_err,
  output logic                    cs_vout,
  output logic [CH_W-1:0]         cs_ch,
  output logic [BLOCK_FRAMES-1:0] cs_data,
  output logic                    cs_crc_err,
  output logic [FR_W-1:0]         frame_idx,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int V_POS = AUX_LEN + DATA_LEN;

  field_state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [SF_LEN-2:0] sr;
  logic [SF_LEN-1:0] word;
  logic take, done, viol, bs, abort;
  logic last_fr, ch_wrap, c_bit;
  logic [CH_W-1:0] ch_idx;
  logic [NUM_CH-1:0][BLOCK_FRAMES-1:0] cs_sr;
  logic [NUM_CH-1:0][7:0] crc;
  logic [NUM_CH-1:0] crc_init, crc_bit;
  logic [BLOCK_FRAMES-1:0] cs_word;
  logic [7:0] crc_next;

  // word is the full subframe when the parity bit is on din
  assign word    = {din, sr};
  assign c_bit   = word[V_POS+2];
  assign bs      = vin & sof & block_start;
  assign last_fr = frame_idx == FR_W'(BLOCK_FRAMES-1);
  assign ch_wrap = ch_idx == CH_W'(NUM_CH-1);
  assign abort   = bs & locked &
                   ((frame_idx != '0) | (ch_idx != '0));
  assign crc_next = crc8_step(crc[ch_idx], c_bit);

  always_comb begin
    cs_word = cs_sr[ch_idx];
    cs_word[frame_idx] = c_bit;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_crc
    assign crc_bit[c]  = done & locked &
                         (ch_idx == CH_W'(c));
    assign crc_init[c] = bs | (crc_bit[c] & last_fr);
    cs_crc8_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .init  (crc_init[c]),
      .bit_v (crc_bit[c]),
      .bit_d (c_bit),
      .crc   (crc[c])
    );
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    done    = 1'b0;
    viol    = 1'b0;
    if (vin && sof) begin
      viol    = state != HUNT;
      take    = 1'b1;
      state_n = AUX;
      cnt_n   = 5'd1;
    end else if (vin) begin
      unique case (state)
        HUNT: begin
        end
        AUX: begin
          take = 1'b1;
          if (cnt == 5'(AUX_LEN-1)) begin
            state_n = DATA;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        DATA: begin
          take = 1'b1;
          if (cnt == 5'(DATA_LEN-1)) begin
            state_n = VALID;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        VALID: begin
          take    = 1'b1;
          state_n = USER;
        end
        USER: begin
          take    = 1'b1;
          state_n = CHAN;
        end
        CHAN: begin
          take    = 1'b1;
          state_n = PARITY;
        end
        PARITY: begin
          done    = 1'b1;
          state_n = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= '0;
      sr          <= '0;
      ch_idx      <= '0;
      frame_idx   <= '0;
      locked      <= 1'b0;
      cs_sr       <= '0;
      sample_vout <= 1'b0;
      sample_data <= '0;
      sample_aux  <= '0;
      sample_ch   <= '0;
      sample_v    <= 1'b0;
      sample_u    <= 1'b0;
      parity_err  <= 1'b0;
      cs_vout     <= 1'b0;
      cs_ch       <= '0;
      cs_data     <= '0;
      cs_crc_err  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sample_vout <= done;
      cs_vout     <= done & locked & last_fr;
      sync_err    <= viol | abort;
      if (take)
        sr <= word[SF_LEN-1:1];
      if (done) begin
        sample_data <= word[V_POS-1 -: SAMPLE_W];
        sample_aux  <= word[AUX_LEN-1:0];
        sample_ch   <= ch_idx;
        sample_v    <= word[V_POS];
        sample_u    <= word[V_POS+1];
        parity_err  <= ^word;
        ch_idx      <= ch_wrap ? '0 : ch_idx + 1'b1;
        if (ch_wrap)
          frame_idx <= last_fr ? '0 : frame_idx + 1'b1;
        if (locked)
          cs_sr[ch_idx][frame_idx] <= c_bit;
        if (locked && last_fr) begin
          cs_ch      <= ch_idx;
          cs_data    <= cs_word;
          cs_crc_err <= crc_next != 8'h00;
        end
      end
      // block_start realigns position and drops any partial block
      if (bs) begin
        ch_idx    <= '0;
        frame_idx <= '0;
        locked    <= 1'b1;
      end
    end
  end

endmodule
